// File: rtl/lcd_msg_arbiter_pkg.sv
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types and constants for the LCD message arbiter slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

   localparam int          LCD_CHARS   = 32;
   localparam int          LINE_CHARS  = 16;
   localparam logic [7:0]  ASCII_SPACE = 8'h20;

   typedef logic [0:15][7:0] lcd_line_t;
   typedef logic [0:31][7:0] lcd_frame_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/lcd_msg_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first eligible index at or after rr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         eligible,
   input  logic [$clog2(NREQ)-1:0] rr,
   output logic                    grant_valid,
   output logic [$clog2(NREQ)-1:0] grant_idx
);

   localparam int IW = $clog2(NREQ);

   int w_best;
   int w_dist;

   // Smallest wrap-around distance from rr wins.
   always_comb begin
      w_best      = NREQ;
      w_dist      = 0;
      grant_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = (i + NREQ - int'(rr)) % NREQ;
         if (eligible[i] && (w_dist < w_best)) begin
            w_best    = w_dist;
            grant_idx = IW'(i);
         end
      end
      grant_valid = (w_best < NREQ);
   end

endmodule

`default_nettype wire

// File: rtl/lcd_msg_arbiter.sv
// ============================================================================
// Module   : lcd_msg_arbiter
// Brief    : Grants one requester at a time and copies its 16-char line into
//            the registered LCD frame, with per-row minimum dwell lockout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_msg_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DWELL = 50_000_000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NREQ-1:0]                   req,
   input  logic [NREQ-1:0]                   line_sel,
   input  lcd_line_t [NREQ-1:0]              msg,
   output logic [NREQ-1:0]                   ack,
   output lcd_frame_t                        ascii,
   output logic                              busy,
   output logic [$clog2(NREQ)-1:0]           owner_top,
   output logic [$clog2(NREQ)-1:0]           owner_bot,
   output logic                              owner_top_v,
   output logic                              owner_bot_v
);

   localparam int IW = $clog2(NREQ);
   localparam int DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

   arb_state_t      r_state, w_state_nxt;
   logic [IW-1:0]   r_grant, r_rr, r_owner_top, r_owner_bot;
   logic            r_row, r_owner_top_v, r_owner_bot_v;
   logic [3:0]      r_k;
   logic [DW-1:0]   r_dwell_top, r_dwell_bot;
   lcd_frame_t      r_ascii;
   logic [NREQ-1:0] w_elig, w_row_free, w_row_own;
   logic            w_grant_valid;
   logic [IW-1:0]   w_grant_idx;

   for (genvar i = 0; i < NREQ; i++) begin : g_elig
      assign w_row_free[i] = line_sel[i] ? (r_dwell_bot == '0) : (r_dwell_top == '0);
      // The current owner may always refresh its own row.
      assign w_row_own[i]  = line_sel[i] ? (r_owner_bot_v && (r_owner_bot == IW'(i)))
                                         : (r_owner_top_v && (r_owner_top == IW'(i)));
      assign w_elig[i]     = req[i] && (w_row_free[i] || w_row_own[i]);
      assign ack[i]        = (r_state == DONE) && (r_grant == IW'(i));
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .eligible    (w_elig),
      .rr          (r_rr),
      .grant_valid (w_grant_valid),
      .grant_idx   (w_grant_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant_valid) w_state_nxt = COPY;
         COPY:    if (r_k == 4'd15)  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_grant       <= '0;
         r_row         <= 1'b0;
         r_k           <= '0;
         r_rr          <= '0;
         r_owner_top   <= '0;
         r_owner_bot   <= '0;
         r_owner_top_v <= 1'b0;
         r_owner_bot_v <= 1'b0;
         r_ascii       <= {LCD_CHARS{ASCII_SPACE}};
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_grant <= w_grant_idx;
                  r_row   <= line_sel[w_grant_idx];
                  r_k     <= '0;
               end
            end
            COPY: begin
               // msg is read live each cycle, not snapshotted at grant.
               r_ascii[{r_row, r_k}] <= msg[r_grant][r_k];
               r_k                   <= r_k + 4'd1;
            end
            DONE: begin
               if (r_row) begin
                  r_owner_bot   <= r_grant;
                  r_owner_bot_v <= 1'b1;
               end else begin
                  r_owner_top   <= r_grant;
                  r_owner_top_v <= 1'b1;
               end
               r_rr <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);
            end
            default: ;
         endcase
      end
   end

   // A DONE load wins over the saturating decrement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dwell_top <= '0;
         r_dwell_bot <= '0;
      end else begin
         if ((r_state == DONE) && !r_row)  r_dwell_top <= DW'(DWELL);
         else if (r_dwell_top != '0)       r_dwell_top <= r_dwell_top - DW'(1);
         if ((r_state == DONE) && r_row)   r_dwell_bot <= DW'(DWELL);
         else if (r_dwell_bot != '0)       r_dwell_bot <= r_dwell_bot - DW'(1);
      end
   end

   assign ascii       = r_ascii;
   assign busy        = (r_state == COPY) || (r_state == DONE);
   assign owner_top   = r_owner_top;
   assign owner_bot   = r_owner_bot;
   assign owner_top_v = r_owner_top_v;
   assign owner_bot_v = r_owner_bot_v;

endmodule

`default_nettype wire

// File: tb/tb_lcd_msg_arbiter.sv
// ============================================================================
// Module   : tb_lcd_msg_arbiter
// Brief    : Self-checking bench for lcd_msg_arbiter against a timestamp model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_msg_arbiter;
   import lcd_pkg::*;

   localparam int N     = 4;
   localparam int DWELL = 100;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    line_sel = '0;
   lcd_line_t [N-1:0] msg;
   logic [N-1:0]    ack;
   lcd_frame_t      ascii;
   logic            busy;
   logic [1:0]      owner_top, owner_bot;
   logic            owner_top_v, owner_bot_v;

   lcd_msg_arbiter #(.NREQ(N), .DWELL(DWELL)) dut (
      .clk(clk), .reset(reset), .req(req), .line_sel(line_sel), .msg(msg),
      .ack(ack), .ascii(ascii), .busy(busy),
      .owner_top(owner_top), .owner_bot(owner_bot),
      .owner_top_v(owner_top_v), .owner_bot_v(owner_bot_v)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [N-1:0] last_ack;

   // Reference: a grant at cycle s writes char k at the end of s+1+k,
   // acks in s+17, and locks the row until s+18+DWELL.
   bit         m_active;
   int         m_start, m_g, m_row, m_rr, m_next_arb;
   int         m_lock [2];
   int         m_own  [2];
   bit         m_ov   [2];
   lcd_frame_t m_frame;

   task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s got %h want %h", nm, a, e);
      end
   endtask

   task automatic m_reset();
      m_active = 0; m_start = 0; m_g = 0; m_row = 0; m_rr = 0; m_next_arb = 0;
      for (int r = 0; r < 2; r++) begin m_lock[r] = 0; m_own[r] = 0; m_ov[r] = 0; end
      for (int c = 0; c < LCD_CHARS; c++) m_frame[c] = ASCII_SPACE;
   endtask

   function automatic bit m_elig(input int i);
      int r = int'(line_sel[i]);
      return req[i] && ((cyc >= m_lock[r]) || (m_ov[r] && m_own[r] == i));
   endfunction

   task automatic m_step();
      int k;
      if (!m_active) begin
         if (cyc >= m_next_arb) begin
            for (int off = 0; off < N; off++) begin
               int i = (m_rr + off) % N;
               if (!m_active && m_elig(i)) begin
                  m_active = 1; m_start = cyc; m_g = i; m_row = int'(line_sel[i]);
               end
            end
         end
      end else begin
         k = cyc - m_start - 1;
         if (k >= 0 && k < LINE_CHARS) m_frame[m_row*LINE_CHARS + k] = msg[m_g][k];
         if (cyc == m_start + 17) begin
            m_own[m_row] = m_g; m_ov[m_row] = 1;
            m_lock[m_row] = cyc + 1 + DWELL;
            m_rr = (m_g + 1) % N;
            m_active = 0; m_next_arb = cyc + 1;
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] e_ack;
      @(negedge clk);
      cyc++;
      last_ack = ack;
      if (!reset) m_reset();
      e_ack = '0;
      if (m_active && cyc == m_start + 17) e_ack[m_g] = 1'b1;
      chk("ack", ack, e_ack);
      chk("busy", busy, m_active);
      chk("owner_top", owner_top, m_own[0][1:0]);
      chk("owner_bot", owner_bot, m_own[1][1:0]);
      chk("owner_top_v", owner_top_v, m_ov[0]);
      chk("owner_bot_v", owner_bot_v, m_ov[1]);
      chk("ascii", ascii, m_frame);
      if (reset) m_step();
      @(posedge clk); #1;
   endtask

   function automatic lcd_line_t s2l(input string s);
      lcd_line_t l;
      for (int k = 0; k < LINE_CHARS; k++) l[k] = (k < s.len()) ? s[k] : ASCII_SPACE;
      return l;
   endfunction

   task automatic wait_ack(input int id, input int drop_at, output int lat);
      lat = -1;
      for (int n = 0; n < 300; n++) begin
         tick();
         if (n == drop_at) req[id] = 1'b0;
         if (last_ack[id]) begin lat = n; break; end
      end
   endtask

   typedef struct {
      int    id;
      bit    row;
      string text;
      int    lat;
      int    otop, obot;
      bit    vt, vb;
   } vec_t;

   function automatic vec_t mkv(input int id, input bit row, input string text,
                                input int lat, input int otop, input int obot,
                                input bit vt, input bit vb);
      vec_t v;
      v.id = id; v.row = row; v.text = text; v.lat = lat;
      v.otop = otop; v.obot = obot; v.vt = vt; v.vb = vb;
      return v;
   endfunction

   initial begin
      vec_t vecs [6];
      int   lat;
      int   ids [4];
      int   at  [4];
      int   na;

      vecs[0] = mkv(1, 1'b0, "SCORE:0042      ", 17,  1, 0, 1, 0);
      vecs[1] = mkv(2, 1'b1, "LIVES: 3",         17,  1, 2, 1, 1);
      vecs[2] = mkv(1, 1'b0, "SCORE:0043",       17,  1, 2, 1, 1);
      vecs[3] = mkv(3, 1'b0, "PAUSED",           116, 3, 2, 1, 1);
      vecs[4] = mkv(0, 1'b1, "BONUS",            17,  3, 0, 1, 1);
      vecs[5] = mkv(2, 1'b1, "GAME OVER",        116, 3, 2, 1, 1);

      for (int i = 0; i < N; i++) msg[i] = s2l("");
      m_reset();
      @(posedge clk); #1;
      tick(); tick();
      reset = 1'b1;
      repeat (3) tick();

      // Directed transactions with explicit latency and ownership.
      foreach (vecs[v]) begin
         msg[vecs[v].id]      = s2l(vecs[v].text);
         line_sel[vecs[v].id] = vecs[v].row;
         req[vecs[v].id]      = 1'b1;
         wait_ack(vecs[v].id, -1, lat);
         req[vecs[v].id] = 1'b0;
         chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
         tick();
         chk($sformatf("vec%0d_otop", v), owner_top, vecs[v].otop[1:0]);
         chk($sformatf("vec%0d_obot", v), owner_bot, vecs[v].obot[1:0]);
         chk($sformatf("vec%0d_vt", v), owner_top_v, vecs[v].vt);
         chk($sformatf("vec%0d_vb", v), owner_bot_v, vecs[v].vb);
         chk($sformatf("vec%0d_row", v),
             vecs[v].row ? ascii[16:31] : ascii[0:15], s2l(vecs[v].text));
      end

      // Round-robin: two rows requested together, rr = 3 so 0 leads.
      repeat (120) tick();
      msg[0] = s2l("TOP ROW"); msg[2] = s2l("BOTTOM ROW");
      line_sel[0] = 1'b0; line_sel[2] = 1'b1;
      req[0] = 1'b1; req[2] = 1'b1;
      na = 0;
      for (int n = 0; n < 200 && na < 4; n++) begin
         tick();
         if (last_ack != '0) begin
            for (int i = 0; i < N; i++) if (last_ack[i]) ids[na] = i;
            at[na] = n;
            na++;
         end
      end
      req[0] = 1'b0; req[2] = 1'b0;
      chk("rr_count", na, 4);
      if (na == 4) begin
         chk("rr_first_lat", at[0], 17);
         for (int j = 0; j < 4; j++) chk($sformatf("rr_id%0d", j), ids[j], (j % 2) * 2);
         for (int j = 1; j < 4; j++) chk($sformatf("rr_gap%0d", j), at[j] - at[j-1], 18);
      end

      // Request dropped while k = 5 is being written.
      repeat (120) tick();
      msg[1] = s2l("DROPPED MIDCOPY!"); line_sel[1] = 1'b1; req[1] = 1'b1;
      wait_ack(1, 5, lat);
      req[1] = 1'b0;
      chk("drop_lat", lat, 17);
      tick();
      chk("drop_row", ascii[16:31], s2l("DROPPED MIDCOPY!"));

      // Asynchronous reset in the middle of a copy.
      repeat (120) tick();
      msg[3] = s2l("LOST LINE"); line_sel[3] = 1'b0; req[3] = 1'b1;
      repeat (8) tick();
      chk("rst_pre_busy", busy, 1'b1);
      reset = 1'b0;
      tick();
      chk("rst_ascii", ascii, {LCD_CHARS{ASCII_SPACE}});
      chk("rst_busy", busy, 1'b0);
      chk("rst_vt", owner_top_v, 1'b0);
      chk("rst_vb", owner_bot_v, 1'b0);
      req[3] = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_idle_busy", busy, 1'b0);

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && !(m_active && m_g == i))
               for (int k = 0; k < LINE_CHARS; k++) msg[i][k] = 8'($urandom_range(65, 90));
            if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 7) == 0) line_sel[i] = ~line_sel[i];
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
